alu_arbiter: RTL and testbench

//   Shares one multi-cycle ALU (start/finished handshake, 5-bit opcode, N-bit A/B in, Y/X out)

---
 rtl/alu_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose
//   Shares one multi-cycle ALU between two requesters. A round-robin arbiter
//   picks a winner in IDLE, captures its opcode/operands into registers that
//   drive the ALU, holds alu_start high while the ALU works, and returns the
//   ALU results for one cycle tagged with the owning requester. A watchdog
//   aborts an operation whose alu_finished never arrives and returns an error
//   response with zeroed results instead.
//
// Ports
//   clock                 in   single clock, rising edge
//   reset                 in   asynchronous, active-low reset
//   req0/req1             in   requester k has an operation pending
//   op0/op1     [4:0]     in   opcode of requester k
//   a0/a1,b0/b1 [N-1:0]   in   operands of requester k
//   ack0/ack1             out  combinational accept strobe (operands taken
//                              on the clock edge ending that cycle)
//   rsp_valid             out  one-cycle result strobe
//   rsp_id                out  requester that owns the result
//   rsp_err               out  1 = watchdog abort (rsp_y/rsp_x are 0)
//   rsp_y/rsp_x [N-1:0]   out  ALU results, held until the next response
//   busy                  out  high while an operation is in RUN or RESP
//   alu_start             out  level start to the ALU, high throughout RUN
//   alu_opcode  [4:0]     out  registered opcode to the ALU
//   alu_a/alu_b [N-1:0]   out  registered operands to the ALU
//   alu_finished          in   ALU completion
//   alu_y/alu_x [N-1:0]   in   ALU results
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [4:0]   op0,
  input  logic [4:0]   op1,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic [N-1:0] rsp_y,
  output logic [N-1:0] rsp_x,
  output logic         busy,
  output logic         alu_start,
  output logic [4:0]   alu_opcode,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic         alu_finished,
  input  logic [N-1:0] alu_y,
  input  logic [N-1:0] alu_x
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4:0]     opcode_q, opcode_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   rsp_y_q, rsp_y_d;
  logic [N-1:0]   rsp_x_q, rsp_x_d;
  logic           rsp_err_q, rsp_err_d;
  logic           rsp_id_q, rsp_id_d;

  logic           req_any;
  logic           win;

  // Round robin: with both requesting, the one that did not win last time
  // goes. last resets to 1 so requester 0 wins the first tie.
  assign req_any = req0 | req1;
  assign win     = (req0 & req1) ? ~last_q : req1;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    opcode_d  = opcode_q;
    a_d       = a_q;
    b_d       = b_q;
    rsp_y_d   = rsp_y_q;
    rsp_x_d   = rsp_x_q;
    rsp_err_d = rsp_err_q;
    rsp_id_d  = rsp_id_q;
    ack0      = 1'b0;
    ack1      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A finished still high in IDLE is stale (left over from a previous
        // exchange); starting now would let it complete the new op at once.
        // The reset term keeps the combinational acks low while in reset.
        if (reset && req_any && !alu_finished) begin
          ack0     = ~win;
          ack1     = win;
          opcode_d = win ? op1 : op0;
          a_d      = win ? a1 : a0;
          b_d      = win ? b1 : b0;
          last_d   = win;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        if (alu_finished) begin
          rsp_y_d   = alu_y;
          rsp_x_d   = alu_x;
          rsp_err_d = 1'b0;
          rsp_id_d  = last_q;
          state_d   = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          // Watchdog abort; counter stays at its last value (no wrap).
          rsp_y_d   = '0;
          rsp_x_d   = '0;
          rsp_err_d = 1'b1;
          rsp_id_d  = last_q;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      opcode_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_y_q   <= '0;
      rsp_x_q   <= '0;
      rsp_err_q <= 1'b0;
      rsp_id_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      opcode_q  <= opcode_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rsp_y_q   <= rsp_y_d;
      rsp_x_q   <= rsp_x_d;
      rsp_err_q <= rsp_err_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

  assign alu_start  = (state_q == S_RUN);
  assign rsp_valid  = (state_q == S_RESP);
  assign busy       = (state_q == S_RUN) || (state_q == S_RESP);
  assign alu_opcode = opcode_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_y      = rsp_y_q;
  assign rsp_x      = rsp_x_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_id     = rsp_id_q;

  // Structural invariants of the handshake.
  a_one_ack : assert property (@(posedge clock) disable iff (!reset)
    !(ack0 && ack1));
  a_rsp_pulse : assert property (@(posedge clock) disable iff (!reset)
    rsp_valid |=> !rsp_valid);
  a_cnt_bound : assert property (@(posedge clock) disable iff (!reset)
    cnt_q <= CNT_LAST);
  a_ack_idle : assert property (@(posedge clock) disable iff (!reset)
    (ack0 || ack1) |-> !busy);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int N = 4;
  localparam int TIMEOUT = 8;

  logic         clock;
  logic         reset;
  logic         req0, req1;
  logic [4:0]   op0, op1;
  logic [N-1:0] a0, a1, b0, b1;
  logic         ack0, ack1;
  logic         rsp_valid, rsp_id, rsp_err;
  logic [N-1:0] rsp_y, rsp_x;
  logic         busy;
  logic         alu_start;
  logic [4:0]   alu_opcode;
  logic [N-1:0] alu_a, alu_b;
  logic         alu_finished;
  logic [N-1:0] alu_y, alu_x;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // ALU model: finishes in the k-th cycle of alu_start (k=0: never).
  int   mdl_k = 0;
  logic mdl_stuck = 1'b0;
  int   alu_cyc = 0;

  typedef struct {
    logic       id;
    logic       err;
    logic [3:0] y;
    logic [3:0] x;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [4:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
    logic [3:0] x;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t v0[2];
  vec_t v1[2];

  alu_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .ack0(ack0), .ack1(ack1),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_y(rsp_y), .rsp_x(rsp_x), .busy(busy),
    .alu_start(alu_start), .alu_opcode(alu_opcode),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_finished(alu_finished), .alu_y(alu_y), .alu_x(alu_x)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(posedge clock) begin
    if (alu_start) alu_cyc <= alu_cyc + 1;
    else           alu_cyc <= 0;
  end

  assign alu_finished = mdl_stuck | (alu_start && (mdl_k != 0) && (alu_cyc == mdl_k - 1));
  assign alu_y = alu_a + alu_b;
  assign alu_x = alu_a & alu_b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic err, input logic [3:0] y,
                          input logic [3:0] x, input int c);
    exp_t e;
    e.id = id; e.err = err; e.y = y; e.x = x; e.cyc = c;
    sb_q.push_back(e);
  endtask

  // Monitor: pops one expectation per response strobe.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (ack0 || ack1) chk("single_ack", 32'(ack0 & ack1), 32'd0);
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          $display("rsp cycle=%0d id=%0d err=%0d y=%0h x=%0h", cyc, rsp_id, rsp_err, rsp_y, rsp_x);
          chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
          chk("rsp_y", 32'(rsp_y), 32'(mon_e.y));
          chk("rsp_x", 32'(rsp_x), 32'(mon_e.x));
          chk("rsp_busy", 32'(busy), 32'd1);
        end
      end
    end
  end

  task automatic wait_ack(input logic id, output int t);
    t = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if ((id ? ack1 : ack0) === 1'b1) begin
        t = cyc;
        break;
      end
    end
    checks++;
    if (t < 0) begin
      errors++;
      $display("FAIL ack_timeout id=%0d got=none expected=ack", id);
    end
  endtask

  // Drives one request, waits for its ack, records the expected response and
  // drops the request the following cycle.
  task automatic issue(input logic id, input logic [4:0] op, input logic [3:0] a,
                       input logic [3:0] b, input int k, input logic [3:0] ey,
                       input logic [3:0] ex, output int t, output int d);
    mdl_k = k;
    @(posedge clock); #1;
    d = cyc;
    if (id) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    wait_ack(id, t);
    $display("ack cycle=%0d id=%0d op=%0h a=%0h b=%0h", t, id, op, a, b);
    if (t >= 0) begin
      if (k == 0) push_exp(id, 1'b1, 4'h0, 4'h0, t + TIMEOUT + 1);
      else        push_exp(id, 1'b0, ey, ex, t + k + 1);
    end
    @(posedge clock); #1;
    if (id) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic check_reset_outs();
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_y", 32'(rsp_y), 32'd0);
    chk("rst_rsp_x", 32'(rsp_x), 32'd0);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int t, d, t1, s, gid, nacc, idx0, idx1;
    v0[0] = '{op: 5'h02, a: 4'h1, b: 4'h2, y: 4'h3, x: 4'h0};
    v0[1] = '{op: 5'h03, a: 4'h5, b: 4'h6, y: 4'hB, x: 4'h4};
    v1[0] = '{op: 5'h04, a: 4'h9, b: 4'h9, y: 4'h2, x: 4'h9};
    v1[1] = '{op: 5'h05, a: 4'hF, b: 4'h1, y: 4'h0, x: 4'h1};

    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    op0 = '0; op1 = '0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    repeat (2) @(negedge clock);
    check_reset_outs();
    @(posedge clock); #1;
    reset = 1'b1;

    // ---- Reset mid-RUN: an accepted op that never finishes is discarded ----
    mdl_k = 0;
    req0 = 1'b1; op0 = 5'h1F; a0 = 4'hA; b0 = 4'h5;
    wait_ack(1'b0, t);
    @(posedge clock); #1;
    req0 = 1'b0;
    @(negedge clock);
    chk("busy_before_reset", 32'(busy), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    mdl_k = 2;
    req0 = 1'b1; op0 = v0[0].op; a0 = v0[0].a; b0 = v0[0].b;
    req1 = 1'b1; op1 = v1[0].op; a1 = v1[0].a; b1 = v1[0].b;
    @(negedge clock);
    check_reset_outs();
    @(posedge clock); #1;
    reset = 1'b1;

    // ---- Both held high: grant order 0,1,0,1 (first tie after reset -> 0) ----
    nacc = 0; idx0 = 0; idx1 = 0;
    for (int i = 0; i < 200 && nacc < 4; i++) begin
      @(negedge clock);
      if (ack0 || ack1) begin
        gid = ack1 ? 1 : 0;
        $display("ack cycle=%0d id=%0d (held requests)", cyc, gid);
        chk("grant_order", 32'(gid), 32'(nacc % 2));
        if ((gid == 1 && idx1 >= 2) || (gid == 0 && idx0 >= 2)) begin
          chk("extra_ack", 32'(gid), 32'(1 - gid));
        end else begin
          if (gid == 1) push_exp(1'b1, 1'b0, v1[idx1].y, v1[idx1].x, cyc + 3);
          else          push_exp(1'b0, 1'b0, v0[idx0].y, v0[idx0].x, cyc + 3);
          @(posedge clock); #1;
          if (gid == 1) begin
            chk("held_opcode", 32'(alu_opcode), 32'(v1[idx1].op));
            idx1++;
            if (idx1 == 2) req1 = 1'b0;
            else begin op1 = v1[idx1].op; a1 = v1[idx1].a; b1 = v1[idx1].b; end
          end else begin
            chk("held_opcode", 32'(alu_opcode), 32'(v0[idx0].op));
            idx0++;
            if (idx0 == 2) req0 = 1'b0;
            else begin op0 = v0[idx0].op; a0 = v0[idx0].a; b0 = v0[idx0].b; end
          end
        end
        nacc++;
      end
    end
    chk("held_accepts", 32'(nacc), 32'd4);
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();

    // ---- Single request, k=3: ack t, start t+1..t+3, rsp at t+4 ----
    issue(1'b0, 5'h01, 4'h3, 4'h4, 3, 4'h7, 4'h0, t, d);
    chk("single_ack_cycle", 32'(t), 32'(d));
    chk("single_opcode", 32'(alu_opcode), 32'h01);
    chk("single_a", 32'(alu_a), 32'h3);
    chk("single_b", 32'(alu_b), 32'h4);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      chk("single_alu_start", 32'(alu_start), 32'(i <= 3));
    end
    wait_idle();

    // ---- Watchdog: never finishes -> error rsp at ack+9, then normal op ----
    issue(1'b0, 5'h1E, 4'h6, 4'h6, 0, 4'h0, 4'h0, t, d);
    wait_idle();
    issue(1'b1, 5'h07, 4'h2, 4'h2, 1, 4'h4, 4'h2, t, d);
    wait_idle();

    // ---- Stale finished in IDLE blocks grant until it falls ----
    mdl_k = 1;
    @(posedge clock); #1;
    mdl_stuck = 1'b1;
    req1 = 1'b1; op1 = 5'h08; a1 = 4'hC; b1 = 4'h3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("stale_no_ack1", 32'(ack1), 32'd0);
    end
    @(posedge clock); #1;
    mdl_stuck = 1'b0;
    s = cyc;
    wait_ack(1'b1, t1);
    $display("ack cycle=%0d id=1 (after stale finished)", t1);
    chk("stale_ack_cycle", 32'(t1), 32'(s));
    if (t1 >= 0) push_exp(1'b1, 1'b0, 4'hF, 4'h0, t1 + 2);
    @(posedge clock); #1;
    req1 = 1'b0;
    wait_idle();

    // ---- req1 raised during req0's RUN: acked the cycle after rsp_valid ----
    issue(1'b0, 5'h09, 4'h2, 4'h3, 3, 4'h5, 4'h2, t, d);
    req1 = 1'b1; op1 = 5'h0A; a1 = 4'h7; b1 = 4'h8;
    wait_ack(1'b1, t1);
    $display("ack cycle=%0d id=1 (raised during RUN)", t1);
    chk("late_ack_cycle", 32'(t1), 32'(t + 5));
    if (t1 >= 0) push_exp(1'b1, 1'b0, 4'hF, 4'h0, t1 + 4);
    @(posedge clock); #1;
    req1 = 1'b0;
    wait_idle();

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
